sync_fifo_read_adapter: RTL

- Read-side companion to the team's synchronous FIFO buffer.
- Drives the FIFO read port (read strobe, empty flag, read data) and converts it into a registered valid/ready output stream.
- Handles both FIFO read modes: FWFT, where data is combinational with the head, and standard, where data arrives one cycle after the read.
- A 2-entry output buffer sustains one word per cycle under backpressure, without overreading the FIFO.

---
 rtl/sync_fifo_read_adapter.sv | 55 +++++
 1 files changed

// File: rtl/sync_fifo_read_adapter.sv
// sync_fifo_read_adapter: turns a synchronous FIFO read port (FWFT or standard) into a registered valid/ready stream
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync discard of buffered/in-flight words)
//   fifo_empty_i, fifo_rd_data_i -> FIFO read side inputs; fifo_read_o -> FIFO pop strobe
//   m_valid_o, m_data_o, m_ready_i -> registered output stream
module sync_fifo_read_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_read_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i
);
  logic [1:0] occ_q, occ_d, occ_pop;
  logic pend_q, pend_d, valid_q, valid_d, pop, cap;
  logic [2:0] fill;
  logic [DATA_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  assign pop = valid_q & m_ready_i & !flush_i;
  // words held or in flight once this cycle's pop retires
  assign fill = {1'b0, occ_q} + {2'b0, pend_q} - {2'b0, pop};
  assign fifo_read_o = !rst_i & !flush_i & !fifo_empty_i & (fill < 3'd2);
  // FWFT data is live with the strobe; standard mode data lands one cycle later
  assign cap = !flush_i & (FWFT ? fifo_read_o : pend_q);
  assign occ_pop = occ_q - {1'b0, pop};
  always_comb begin
    occ_d   = flush_i ? 2'd0 : occ_pop + {1'b0, cap};
    pend_d  = FWFT ? 1'b0 : fifo_read_o;
    valid_d = occ_d != 2'd0;
    s0_d    = (cap && occ_pop == 2'd0) ? fifo_rd_data_i : (pop && occ_q == 2'd2) ? s1_q : s0_q;
    s1_d    = (cap && occ_pop != 2'd0) ? fifo_rd_data_i : s1_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q   <= 2'd0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end
  assign m_valid_o = valid_q;
  assign m_data_o  = s0_q;
endmodule
